dual_slope_ctrl: RTL and testbench

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

---
 rtl/dual_slope_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed integrate, timed de-integrate.
// The de-integrate count becomes the result; saturation and timeout flag overrange.
module dual_slope_ctrl #(
    parameter int CNT_W      = 16,
    parameter int AZ_CYCLES  = 1000,
    parameter int INT_CYCLES = 10000,
    parameter int DEINT_MAX  = 20000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [2:0]       range_i,
    input  logic [1:0]       mode_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    input  logic             ref_ok_i,
    output logic [1:0]       afe_sel_o,
    output logic [2:0]       range_sel_o,
    output logic [1:0]       mode_sel_o,
    output logic             afe_reset_o,
    output logic             ref_sign_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             sign_o,
    output logic             overrange_o,
    output logic             result_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_REF,
        S_AUTOZERO,
        S_INTEGRATE,
        S_DEINT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] AZ_LAST    = CNT_W'(AZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(INT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(DEINT_MAX - 1);
    localparam logic [CNT_W-1:0] DEINT_TOP  = CNT_W'(DEINT_MAX);

    // Reset asserts asynchronously but releases two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // AFE status lines: bit 0 comp, 1 sat_hi, 2 sat_lo, 3 ref_ok.
    logic [3:0] afe_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic       comp_s;
    logic       sat_s;
    logic       ref_s;

    assign afe_raw = {ref_ok_i, sat_lo_i, sat_hi_i, comp_i};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk_i or negedge rst_n_int) begin
                if (!rst_n_int) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                end else begin
                    sync1_q[gi] <= afe_raw[gi];
                    sync2_q[gi] <= sync1_q[gi];
                end
            end
        end
    endgenerate

    assign comp_s = sync2_q[0];
    assign sat_s  = sync2_q[1] | sync2_q[2];
    assign ref_s  = sync2_q[3];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pol_q, pol_d;
    logic [2:0]       range_q, range_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] res_d;
    logic             ovr_d;

    logic [1:0]       afe_sel_q;
    logic             afe_reset_q;
    logic             ref_sign_q;
    logic             busy_q;
    logic [CNT_W-1:0] result_q;
    logic             sign_q;
    logic             overrange_q;
    logic             valid_q;

    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            S_AUTOZERO:  sel_of = 2'b01;
            S_INTEGRATE: sel_of = 2'b10;
            S_DEINT:     sel_of = 2'b11;
            default:     sel_of = 2'b00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pol_d   = pol_q;
        range_d = range_q;
        mode_d  = mode_q;
        res_d   = result_q;
        ovr_d   = overrange_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_ARM;
                    range_d = range_i;
                    mode_d  = mode_i;
                    pol_d   = 1'b0;
                end
            end
            S_ARM: begin
                state_d = S_WAIT_REF;
                cnt_d   = '0;
            end
            S_WAIT_REF: begin
                if (ref_s) begin
                    state_d = S_AUTOZERO;
                    cnt_d   = '0;
                end
            end
            S_AUTOZERO: begin
                if (sat_s) begin
                    state_d = S_DONE;
                    res_d   = '1;
                    ovr_d   = 1'b1;
                end else if (cnt_q == AZ_LAST) begin
                    state_d = S_INTEGRATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INTEGRATE: begin
                if (sat_s) begin
                    state_d = S_DONE;
                    res_d   = '1;
                    ovr_d   = 1'b1;
                end else if (cnt_q == INT_LAST) begin
                    state_d = S_DEINT;
                    cnt_d   = '0;
                    pol_d   = comp_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DEINT: begin
                // Zero crossing is taken at face value; synchronizer delay stays in the count.
                if (sat_s) begin
                    state_d = S_DONE;
                    res_d   = '1;
                    ovr_d   = 1'b1;
                end else if (comp_s != pol_q) begin
                    state_d = S_DONE;
                    res_d   = cnt_q;
                    ovr_d   = 1'b0;
                end else if (cnt_q == DEINT_LAST) begin
                    state_d = S_DONE;
                    res_d   = DEINT_TOP;
                    ovr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DONE is allowed to finish so a completed result is never lost.
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pol_q       <= 1'b0;
            range_q     <= 3'b000;
            mode_q      <= 2'b00;
            afe_sel_q   <= 2'b00;
            afe_reset_q <= 1'b0;
            ref_sign_q  <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            sign_q      <= 1'b0;
            overrange_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pol_q       <= pol_d;
            range_q     <= range_d;
            mode_q      <= mode_d;
            afe_sel_q   <= sel_of(state_d);
            afe_reset_q <= (state_d == S_ARM);
            ref_sign_q  <= (state_d == S_DEINT) && pol_d;
            busy_q      <= (state_d != S_IDLE);
            valid_q     <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                result_q    <= res_d;
                sign_q      <= pol_d;
                overrange_q <= ovr_d;
            end
        end
    end

    assign afe_sel_o      = afe_sel_q;
    assign range_sel_o    = range_q;
    assign mode_sel_o     = mode_q;
    assign afe_reset_o    = afe_reset_q;
    assign ref_sign_o     = ref_sign_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign sign_o         = sign_q;
    assign overrange_o    = overrange_q;
    assign result_valid_o = valid_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl: table of full conversions plus
// hand-written abort, start-while-busy and reset sequences.
module tb_dual_slope_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i;
    logic [2:0]  range_i;
    logic [1:0]  mode_i;
    logic        comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
    logic [1:0]  afe_sel_o;
    logic [2:0]  range_sel_o;
    logic [1:0]  mode_sel_o;
    logic        afe_reset_o, ref_sign_o, busy_o;
    logic [15:0] result_o;
    logic        sign_o, overrange_o, result_valid_o;

    always #5 clk = ~clk;

    dual_slope_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .range_i        (range_i),
        .mode_i         (mode_i),
        .comp_i         (comp_i),
        .sat_hi_i       (sat_hi_i),
        .sat_lo_i       (sat_lo_i),
        .ref_ok_i       (ref_ok_i),
        .afe_sel_o      (afe_sel_o),
        .range_sel_o    (range_sel_o),
        .mode_sel_o     (mode_sel_o),
        .afe_reset_o    (afe_reset_o),
        .ref_sign_o     (ref_sign_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .sign_o         (sign_o),
        .overrange_o    (overrange_o),
        .result_valid_o (result_valid_o)
    );

    // Cycle monitor, sampled 2 ns after each rising edge.
    int mon_sel [4] = '{default: 0};
    int mon_rst   = 0;
    int mon_valid = 0;

    always begin
        @(posedge clk);
        #2;
        mon_sel[afe_sel_o] = mon_sel[afe_sel_o] + 1;
        mon_rst   = mon_rst + int'(afe_reset_o);
        mon_valid = mon_valid + int'(result_valid_o);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp);
    endtask

    task automatic check_rng(input string nm, input int got, input int lo, input int hi);
        n_checks++;
        if (got >= lo && got <= hi) n_pass++;
        else $display("FAIL %s: got %0d required %0d..%0d", nm, got, lo, hi);
    endtask

    task automatic wait_sel(input string nm, input logic [1:0] v, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (afe_sel_o == v) ok = 1'b1;
        end
        check({nm, "_reached"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string nm, input int bound, output int n);
        n = 0;
        while (!result_valid_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid_seen"}, 32'(result_valid_o), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},    32'(busy_o),         32'd0);
        check({tag, "_sel"},     32'(afe_sel_o),      32'd0);
        check({tag, "_afe_rst"}, 32'(afe_reset_o),    32'd0);
        check({tag, "_refsign"}, 32'(ref_sign_o),     32'd0);
        check({tag, "_range"},   32'(range_sel_o),    32'd0);
        check({tag, "_mode"},    32'(mode_sel_o),     32'd0);
        check({tag, "_result"},  32'(result_o),       32'd0);
        check({tag, "_sign"},    32'(sign_o),         32'd0);
        check({tag, "_ovr"},     32'(overrange_o),    32'd0);
        check({tag, "_valid"},   32'(result_valid_o), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    typedef struct {
        string name;
        bit    comp;      // comp_i level through integrate
        int    flip;      // cycles into DEINT when comp_i toggles, -1 never
        int    sat_at;    // cycles into INTEGRATE when sat_lo_i rises, -1 never
        bit    chk_sign;
        bit    exp_sign;
        bit    exp_ovr;
        int    res_lo;
        int    res_hi;
        int    exp_int;   // 0 skips the integrate-length check
        int    exp_deint; // 0 skips the de-integrate-length check
    } vec_t;

    vec_t tbl [4];

    task automatic run_vec(input vec_t v);
        int s_az, s_int, s_de, s_rst, n;
        comp_i   = v.comp;
        sat_lo_i = 1'b0;
        ref_ok_i = 1'b1;
        range_i  = 3'd5;
        mode_i   = 2'd2;
        repeat (4) @(negedge clk);
        s_az  = mon_sel[1];
        s_int = mon_sel[2];
        s_de  = mon_sel[3];
        s_rst = mon_rst;
        pulse_start();
        check({v.name, "_busy"},  32'(busy_o),      32'd1);
        check({v.name, "_range"}, 32'(range_sel_o), 32'd5);
        check({v.name, "_mode"},  32'(mode_sel_o),  32'd2);
        if (v.sat_at >= 0) begin
            wait_sel({v.name, "_int"}, 2'b10, 2000);
            repeat (v.sat_at) @(negedge clk);
            sat_lo_i = 1'b1;
            wait_valid(v.name, 10, n);
            check_rng({v.name, "_sat_latency"}, n, 1, 3);
        end else begin
            wait_sel({v.name, "_deint"}, 2'b11, 12000);
            if (v.chk_sign) check({v.name, "_refsign"}, 32'(ref_sign_o), 32'(v.exp_sign));
            if (v.flip >= 0) begin
                repeat (v.flip) @(negedge clk);
                comp_i = ~v.comp;
            end
            wait_valid(v.name, 25000, n);
        end
        if (v.chk_sign) check({v.name, "_sign"}, 32'(sign_o), 32'(v.exp_sign));
        check({v.name, "_ovr"}, 32'(overrange_o), 32'(v.exp_ovr));
        check_rng({v.name, "_result"}, int'(result_o), v.res_lo, v.res_hi);
        check({v.name, "_az_len"}, 32'(mon_sel[1] - s_az), 32'd1000);
        check({v.name, "_arm_len"}, 32'(mon_rst - s_rst), 32'd1);
        if (v.exp_int != 0) check({v.name, "_int_len"}, 32'(mon_sel[2] - s_int), 32'(v.exp_int));
        if (v.exp_deint != 0) check({v.name, "_deint_len"}, 32'(mon_sel[3] - s_de), 32'(v.exp_deint));
        @(negedge clk);
        check({v.name, "_strobe_1cyc"}, 32'(result_valid_o), 32'd0);
        check({v.name, "_idle_busy"}, 32'(busy_o), 32'd0);
        check_rng({v.name, "_result_hold"}, int'(result_o), v.res_lo, v.res_hi);
        sat_lo_i = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_val, s_rst;

        tbl[0] = '{"normal",   1'b1, 3000, -1,   1'b1, 1'b1, 1'b0, 3002,  3003,  10000, 0};
        tbl[1] = '{"negative", 1'b0, 500,  -1,   1'b1, 1'b0, 1'b0, 502,   503,   10000, 0};
        tbl[2] = '{"timeout",  1'b1, -1,   -1,   1'b1, 1'b1, 1'b1, 20000, 20000, 10000, 20000};
        tbl[3] = '{"sat_lo",   1'b1, -1,   2000, 1'b0, 1'b0, 1'b1, 65535, 65535, 0,     0};

        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        range_i = 3'd0; mode_i = 2'd0;
        comp_i = 1'b0; sat_hi_i = 1'b0; sat_lo_i = 1'b0; ref_ok_i = 1'b0;
        #2;
        check_reset("por");
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Abort in auto-zero, with a start attempt while busy.
        comp_i = 1'b1; ref_ok_i = 1'b1; range_i = 3'd1; mode_i = 2'd1;
        repeat (4) @(negedge clk);
        s_val = mon_valid;
        s_rst = mon_rst;
        pulse_start();
        wait_sel("abort_az", 2'b01, 50);
        repeat (10) @(negedge clk);
        range_i = 3'd6;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_start_range", 32'(range_sel_o), 32'd1);
        check("busy_start_sel", 32'(afe_sel_o), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_sel", 32'(afe_sel_o), 32'd0);
        check("abort_result_hold", 32'(result_o), 32'd65535);
        check("abort_ovr_hold", 32'(overrange_o), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_no_valid", 32'(mon_valid - s_val), 32'd0);

        // start and abort together in IDLE: abort wins.
        range_i = 3'd3;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_abort_busy", 32'(busy_o), 32'd0);
        check("start_abort_range", 32'(range_sel_o), 32'd1);
        repeat (2) @(negedge clk);
        check("start_abort_idle", 32'(busy_o), 32'd0);
        check("start_abort_arms", 32'(mon_rst - s_rst), 32'd1);

        // Reset mid-DEINT, release with reference not ready.
        comp_i = 1'b1; range_i = 3'd7; mode_i = 2'd3;
        pulse_start();
        wait_sel("rst_deint", 2'b11, 12000);
        repeat (100) @(negedge clk);
        s_val = mon_valid;
        rst_ni = 1'b0;
        #1;
        check_reset("rst_mid");
        ref_ok_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check_reset("rst_release");
        pulse_start();
        repeat (50) @(negedge clk);
        check("wait_ref_busy", 32'(busy_o), 32'd1);
        check("wait_ref_sel", 32'(afe_sel_o), 32'd0);
        check("rst_no_valid", 32'(mon_valid - s_val), 32'd0);
        ref_ok_i = 1'b1;
        wait_sel("ref_ready_az", 2'b01, 10);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("final_idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
